hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the decode stage. It generates the `stall` and `flush` controls for fetch/decode and a bubble into execute. It sequences load-use interlocks, control-flow redirects from execute, and synchronous trap entry for ECALL/EBREAK flagged by decode. It sits beside the decode stage and owns the fetch PC override.

## Interface
Parameters:
- `XLEN`, 64: PC/address width.
- `LOAD_LAT`, 2: total stall cycles for a load-use hazard; legal range 1..15.
- `DRAIN_CYCLES`, 2: cycles between trap acceptance and vector fetch, letting older instructions retire; legal range 1..15.

Ports (one clock `clk`; reset `resetn` is asynchronous, active-low):
- `clk`  in  1  clock.
- `resetn`  in  1  async active-low reset.
- `id_valid`  in  1  decode holds a valid instruction.
- `id_rs1`, `id_rs2`  in  5  decode source registers.
- `id_uses_rs1`, `id_uses_rs2`  in  1  source actually read.
- `id_pc`  in  XLEN  PC of decode instruction.
- `id_trap`  in  1  decode flags ECALL/EBREAK.
- `id_trap_cause`  in  4  trap cause code.
- `ex_rd`  in  5  execute destination.
- `ex_mem_read`  in  1  execute instruction is a load.
- `ex_redirect`  in  1  taken branch/jump resolved in execute.
- `ex_redirect_pc`  in  XLEN  redirect target.
- `mtvec`  in  XLEN  trap vector base.
- `if_stall`, `id_stall`  out  1  hold fetch/decode.
- `id_flush`, `ex_flush`  out  1  squash decode/execute input.
- `pc_redirect`  out  1  fetch PC override valid.
- `redirect_pc`  out  XLEN  override target.
- `trap_taken`  out  1  one-cycle trap-entry pulse.
- `mepc`  out  XLEN  latched trapping PC.
- `mcause`  out  XLEN  zero-extended latched cause.
- `perf_stall_cycles`, `perf_flushes`  out  32  performance counters.

## Operation
- FSM states: RUN, LOAD_WAIT, TRAP_DRAIN, TRAP_ENTER. All stall/flush/redirect outputs are combinational from state and inputs. `mepc`, `mcause` and the counters are registered.
- Load-use hazard: `id_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- RUN:
  - Priority is redirect > trap > load-use.
  - Redirect: `id_flush=ex_flush=pc_redirect=1`, `redirect_pc=ex_redirect_pc`; stay in RUN.
  - Trap (`id_valid & id_trap`): latch `mepc=id_pc`, `mcause={0,id_trap_cause}`; assert `if_stall`, `id_flush`; load counter with `DRAIN_CYCLES-1`. Go to TRAP_DRAIN, or to TRAP_ENTER if `DRAIN_CYCLES==1`.
  - Load-use: assert `if_stall`, `id_stall`, `ex_flush`. If `LOAD_LAT>1`, load counter with `LOAD_LAT-1` and go to LOAD_WAIT.
- LOAD_WAIT: assert `if_stall`, `id_stall`, `ex_flush`; decrement counter; return to RUN in the cycle the counter reads 1. An `ex_redirect` here aborts to RUN and performs the redirect.
- TRAP_DRAIN: assert `if_stall`, `id_flush`; decrement counter; go to TRAP_ENTER when the counter reads 1. An `ex_redirect` here (older instruction) cancels the trap: perform the redirect, go to RUN, leave `mepc`/`mcause` unchanged from the latched value.
- TRAP_ENTER: assert `pc_redirect=1`, `redirect_pc=mtvec`, `trap_taken=1`, `id_flush=1`; next state RUN.
- Otherwise `redirect_pc=0`.

## Timing
- Reset: state RUN, counter 0, all outputs 0, `mepc=0`, `mcause=0`, counters 0. Reset mid-sequence aborts immediately.
- Redirect latency: 0 cycles; outputs react in the same cycle as `ex_redirect`.
- Load-use: exactly `LOAD_LAT` consecutive stall cycles, starting with the detection cycle.
- Trap: `trap_taken` fires `DRAIN_CYCLES` cycles after the accepting cycle.
- Simultaneous `ex_redirect` and `id_trap`: the redirect wins and the trap is not latched.

## Configuration
- `HAZARD_CTRL_PERF_EN`
  - Defined: `perf_stall_cycles` increments every cycle `id_stall=1`; `perf_flushes` increments every cycle `id_flush=1`. Both saturate at 32'hFFFFFFFF and are cleared by reset.
  - Undefined: both ports are tied to 0 and no counter logic is synthesized.

## Test plan
- Load-use, `LOAD_LAT=2`: `ex_mem_read=1`, `ex_rd=5`, `id_rs1=5`, `id_uses_rs1=1` -> `id_stall`/`ex_flush` high for exactly 2 cycles, then low.
- Load into x0: `ex_rd=0`, `id_rs1=0` -> no stall.
- Branch: `ex_redirect=1`, `ex_redirect_pc=0x1000` while a hazard is present -> same cycle `pc_redirect=1`, `redirect_pc=0x1000`, `id_flush=ex_flush=1`, no stall.
- ECALL: `id_trap=1`, cause 8, `id_pc=0x80`, `mtvec=0x200`, `DRAIN_CYCLES=2` -> `mepc=0x80`, `mcause=8`; 2 cycles later a one-cycle `trap_taken` with `redirect_pc=0x200`.
- Trap cancel: `ex_redirect` to 0x40 during TRAP_DRAIN -> redirect to 0x40, no `trap_taken`, state RUN.
- Reset asserted in LOAD_WAIT -> all outputs 0 asynchronously; RUN after release. With `HAZARD_CTRL_PERF_EN`, 3 stall cycles -> `perf_stall_cycles=3`.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode-stage hazard control bundle between pipeline and hazard_ctrl
interface hazard_ctrl_if #(
  parameter int XLEN = 64
);
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [XLEN-1:0] id_pc;
  logic            id_trap;
  logic [3:0]      id_trap_cause;
  logic [4:0]      ex_rd;
  logic            ex_mem_read;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_redirect_pc;
  logic [XLEN-1:0] mtvec;
  logic            if_stall;
  logic            id_stall;
  logic            id_flush;
  logic            ex_flush;
  logic            pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_taken;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_flushes;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_pc, id_trap, id_trap_cause,
    output ex_rd, ex_mem_read, ex_redirect, ex_redirect_pc, mtvec,
    input  if_stall, id_stall, id_flush, ex_flush, pc_redirect, redirect_pc, trap_taken,
    input  mepc, mcause, perf_stall_cycles, perf_flushes
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_pc, id_trap, id_trap_cause,
    input  ex_rd, ex_mem_read, ex_redirect, ex_redirect_pc, mtvec,
    output if_stall, id_stall, id_flush, ex_flush, pc_redirect, redirect_pc, trap_taken,
    output mepc, mcause, perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use interlock, execute redirect and trap-entry sequencing for decode
// Optional performance counters enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int XLEN         = 64,
  parameter int LOAD_LAT     = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input logic         clk,
  input logic         resetn,
  hazard_ctrl_if.slave bus
);
  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT  = 2'd1;
  localparam logic [1:0] S_TRAP_DRAIN = 2'd2;
  localparam logic [1:0] S_TRAP_ENTER = 2'd3;

  localparam logic [3:0] LOAD_INIT  = 4'(LOAD_LAT - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  logic [1:0]      state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            latch_trap;
  logic            redirect_now;
  logic            load_use;
  logic            if_stall_c, id_stall_c, id_flush_c, ex_flush_c;
  logic            pc_redirect_c, trap_taken_c;
  logic [XLEN-1:0] redirect_pc_c;
  logic [XLEN-1:0] mepc_q, mcause_q;

  assign load_use = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    if_stall_c    = 1'b0;
    id_stall_c    = 1'b0;
    id_flush_c    = 1'b0;
    ex_flush_c    = 1'b0;
    pc_redirect_c = 1'b0;
    trap_taken_c  = 1'b0;
    redirect_pc_c = '0;
    redirect_now  = 1'b0;
    latch_trap    = 1'b0;
    state_nxt     = state;
    cnt_nxt       = cnt;
    case (state)
      S_RUN: begin
        if (bus.ex_redirect) begin
          redirect_now = 1'b1;
        end else if (bus.id_valid && bus.id_trap) begin
          if_stall_c = 1'b1;
          id_flush_c = 1'b1;
          latch_trap = 1'b1;
          cnt_nxt    = DRAIN_INIT;
          state_nxt  = (DRAIN_CYCLES == 1) ? S_TRAP_ENTER : S_TRAP_DRAIN;
        end else if (load_use) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_flush_c = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_nxt   = LOAD_INIT;
            state_nxt = S_LOAD_WAIT;
          end
        end
      end
      S_LOAD_WAIT: begin
        if (bus.ex_redirect) begin
          redirect_now = 1'b1;
          cnt_nxt      = 4'd0;
          state_nxt    = S_RUN;
        end else begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_flush_c = 1'b1;
          cnt_nxt    = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = S_RUN;
        end
      end
      S_TRAP_DRAIN: begin
        // A redirect here comes from an older instruction, so the pending trap is void.
        if (bus.ex_redirect) begin
          redirect_now = 1'b1;
          cnt_nxt      = 4'd0;
          state_nxt    = S_RUN;
        end else begin
          if_stall_c = 1'b1;
          id_flush_c = 1'b1;
          cnt_nxt    = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = S_TRAP_ENTER;
        end
      end
      default: begin
        pc_redirect_c = 1'b1;
        redirect_pc_c = bus.mtvec;
        trap_taken_c  = 1'b1;
        id_flush_c    = 1'b1;
        state_nxt     = S_RUN;
      end
    endcase
    if (redirect_now) begin
      id_flush_c    = 1'b1;
      ex_flush_c    = 1'b1;
      pc_redirect_c = 1'b1;
      redirect_pc_c = bus.ex_redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_RUN;
      cnt      <= 4'd0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch_trap) begin
        mepc_q   <= bus.id_pc;
        mcause_q <= {{(XLEN-4){1'b0}}, bus.id_trap_cause};
      end
    end
  end

  // Controls are held low while reset is asserted, even with live inputs.
  assign bus.if_stall    = resetn & if_stall_c;
  assign bus.id_stall    = resetn & id_stall_c;
  assign bus.id_flush    = resetn & id_flush_c;
  assign bus.ex_flush    = resetn & ex_flush_c;
  assign bus.pc_redirect = resetn & pc_redirect_c;
  assign bus.trap_taken  = resetn & trap_taken_c;
  assign bus.redirect_pc = resetn ? redirect_pc_c : '0;
  assign bus.mepc        = mepc_q;
  assign bus.mcause      = mcause_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (id_stall_c && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (id_flush_c && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = stall_cnt;
  assign bus.perf_flushes      = flush_cnt;
`else
  assign bus.perf_stall_cycles = 32'd0;
  assign bus.perf_flushes      = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checking of hazard_ctrl against a cycle-count model
module tb_hazard_ctrl;
  localparam int XLEN         = 64;
  localparam int LOAD_LAT     = 2;
  localparam int DRAIN_CYCLES = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(XLEN)) bus ();

  hazard_ctrl #(.XLEN(XLEN), .LOAD_LAT(LOAD_LAT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: remaining forced stall cycles and cycles left until trap entry.
  int          m_load_left, m_trap_wait, n_load_left, n_trap_wait;
  logic [63:0] m_mepc, m_mcause, n_mepc, n_mcause;
  longint      m_perf_stall, m_perf_flush;
  logic        e_if_stall, e_id_stall, e_id_flush, e_ex_flush, e_pc_redirect, e_trap_taken;
  logic [63:0] e_redirect_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load_left = 0; m_trap_wait = 0;
    m_mepc = 0; m_mcause = 0;
    m_perf_stall = 0; m_perf_flush = 0;
  endtask

  task automatic set_idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.id_pc = 0; bus.id_trap = 0; bus.id_trap_cause = 0; bus.ex_rd = 0; bus.ex_mem_read = 0;
    bus.ex_redirect = 0; bus.ex_redirect_pc = 0; bus.mtvec = 0;
  endtask

  task automatic set_redirect_out();
    e_id_flush = 1; e_ex_flush = 1; e_pc_redirect = 1; e_redirect_pc = bus.ex_redirect_pc;
  endtask

  task automatic model_eval();
    bit hz;
    hz = bus.id_valid && bus.ex_mem_read && bus.ex_rd != 0 &&
         ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    {e_if_stall, e_id_stall, e_id_flush, e_ex_flush, e_pc_redirect, e_trap_taken} = '0;
    e_redirect_pc = 0;
    n_load_left = m_load_left; n_trap_wait = m_trap_wait; n_mepc = m_mepc; n_mcause = m_mcause;
    if (m_trap_wait == 1) begin
      e_pc_redirect = 1; e_redirect_pc = bus.mtvec; e_trap_taken = 1; e_id_flush = 1;
      n_trap_wait = 0;
    end else if (m_trap_wait > 1) begin
      if (bus.ex_redirect) begin set_redirect_out(); n_trap_wait = 0; end
      else begin e_if_stall = 1; e_id_flush = 1; n_trap_wait = m_trap_wait - 1; end
    end else if (m_load_left > 0) begin
      if (bus.ex_redirect) begin set_redirect_out(); n_load_left = 0; end
      else begin e_if_stall = 1; e_id_stall = 1; e_ex_flush = 1; n_load_left = m_load_left - 1; end
    end else if (bus.ex_redirect) begin
      set_redirect_out();
    end else if (bus.id_valid && bus.id_trap) begin
      e_if_stall = 1; e_id_flush = 1;
      n_mepc = bus.id_pc; n_mcause = 64'(bus.id_trap_cause);
      n_trap_wait = DRAIN_CYCLES;
    end else if (hz) begin
      e_if_stall = 1; e_id_stall = 1; e_ex_flush = 1;
      n_load_left = LOAD_LAT - 1;
    end
  endtask

  // Compare this cycle's outputs against the model, clock, then check registered state.
  task automatic run_cycle();
    model_eval();
    chk("if_stall", bus.if_stall, e_if_stall);
    chk("id_stall", bus.id_stall, e_id_stall);
    chk("id_flush", bus.id_flush, e_id_flush);
    chk("ex_flush", bus.ex_flush, e_ex_flush);
    chk("pc_redirect", bus.pc_redirect, e_pc_redirect);
    chk("redirect_pc", bus.redirect_pc, e_redirect_pc);
    chk("trap_taken", bus.trap_taken, e_trap_taken);
    @(posedge clk);
    m_load_left = n_load_left; m_trap_wait = n_trap_wait; m_mepc = n_mepc; m_mcause = n_mcause;
    if (e_id_stall) m_perf_stall++;
    if (e_id_flush) m_perf_flush++;
    #1;
    chk("mepc", bus.mepc, m_mepc);
    chk("mcause", bus.mcause, m_mcause);
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_stall", 64'(bus.perf_stall_cycles), 64'(m_perf_stall));
    chk("perf_flush", 64'(bus.perf_flushes), 64'(m_perf_flush));
`else
    chk("perf_stall_off", 64'(bus.perf_stall_cycles), 64'd0);
    chk("perf_flush_off", 64'(bus.perf_flushes), 64'd0);
`endif
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_stall"}, bus.if_stall, 0);
    chk({tag, "_id_stall"}, bus.id_stall, 0);
    chk({tag, "_id_flush"}, bus.id_flush, 0);
    chk({tag, "_ex_flush"}, bus.ex_flush, 0);
    chk({tag, "_pc_redirect"}, bus.pc_redirect, 0);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, 0);
    chk({tag, "_trap_taken"}, bus.trap_taken, 0);
    chk({tag, "_mepc"}, bus.mepc, 0);
    chk({tag, "_mcause"}, bus.mcause, 0);
    chk({tag, "_perf_stall"}, 64'(bus.perf_stall_cycles), 0);
  endtask

  task automatic set_hazard();
    bus.id_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_uses_rs1 = 1;
  endtask

  task automatic do_reset();
    resetn = 0;
    #1;
    chk_all_zero("reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    set_idle();
    model_reset();
    #1;
    chk_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    resetn = 1;

    // Load-use: two stall cycles, then released.
    set_hazard(); #1;
    chk("lu_c0_stall", bus.id_stall, 1); chk("lu_c0_exflush", bus.ex_flush, 1);
    run_cycle();
    bus.ex_mem_read = 0; #1;
    chk("lu_c1_stall", bus.id_stall, 1); chk("lu_c1_exflush", bus.ex_flush, 1);
    run_cycle();
    #1;
    chk("lu_c2_stall", bus.id_stall, 0);
    run_cycle();

    // Load into x0 never interlocks.
    set_idle(); bus.id_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_uses_rs1 = 1; #1;
    chk("x0_stall", bus.id_stall, 0);
    run_cycle();

    // Branch with a hazard present: redirect wins the same cycle.
    set_idle(); set_hazard(); bus.ex_redirect = 1; bus.ex_redirect_pc = 64'h1000; #1;
    chk("br_pc_redirect", bus.pc_redirect, 1); chk("br_redirect_pc", bus.redirect_pc, 64'h1000);
    chk("br_id_flush", bus.id_flush, 1); chk("br_ex_flush", bus.ex_flush, 1);
    chk("br_stall", bus.id_stall, 0);
    run_cycle();

    // ECALL with DRAIN_CYCLES=2.
    set_idle(); bus.id_valid = 1; bus.id_trap = 1; bus.id_trap_cause = 8; bus.id_pc = 64'h80; bus.mtvec = 64'h200; #1;
    chk("ecall_if_stall", bus.if_stall, 1);
    run_cycle();
    chk("ecall_mepc", bus.mepc, 64'h80); chk("ecall_mcause", bus.mcause, 64'd8);
    bus.id_valid = 0; bus.id_trap = 0; #1;
    chk("ecall_drain_taken", bus.trap_taken, 0);
    run_cycle();
    #1;
    chk("ecall_taken", bus.trap_taken, 1); chk("ecall_vec", bus.redirect_pc, 64'h200);
    run_cycle();
    #1;
    chk("ecall_taken_once", bus.trap_taken, 0);
    run_cycle();

    // Trap cancelled by an older redirect during drain.
    set_idle(); bus.id_valid = 1; bus.id_trap = 1; bus.id_trap_cause = 3; bus.id_pc = 64'h90; bus.mtvec = 64'h200; #1;
    run_cycle();
    set_idle(); bus.mtvec = 64'h200; bus.ex_redirect = 1; bus.ex_redirect_pc = 64'h40; #1;
    chk("cancel_redirect_pc", bus.redirect_pc, 64'h40); chk("cancel_taken", bus.trap_taken, 0);
    run_cycle();
    bus.ex_redirect = 0; #1;
    chk("cancel_after_taken", bus.trap_taken, 0); chk("cancel_after_redir", bus.pc_redirect, 0);
    chk("cancel_mepc", bus.mepc, 64'h90);
    run_cycle();

    // Reset while in LOAD_WAIT with a hazard still on the inputs.
    set_idle(); set_hazard(); #1;
    run_cycle();
    do_reset();
    set_idle(); #1;
    chk("post_reset_stall", bus.id_stall, 0);
    run_cycle();

    // Three stall cycles: full load-use, then a second one aborted by redirect.
    set_hazard(); #1; run_cycle();
    set_idle(); #1; run_cycle();
    #1; run_cycle();
    set_hazard(); #1; run_cycle();
    set_idle(); bus.ex_redirect = 1; bus.ex_redirect_pc = 64'h44; #1; run_cycle();
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_stall_lit", 64'(bus.perf_stall_cycles), 64'd3);
    chk("perf_flush_lit", 64'(bus.perf_flushes), 64'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      bus.id_valid       = ($urandom_range(0, 9) < 8);
      bus.id_rs1         = 5'($urandom_range(0, 3));
      bus.id_rs2         = 5'($urandom_range(0, 3));
      bus.id_uses_rs1    = 1'($urandom);
      bus.id_uses_rs2    = 1'($urandom);
      bus.id_pc          = {$urandom, $urandom};
      bus.id_trap        = ($urandom_range(0, 99) < 8);
      bus.id_trap_cause  = 4'($urandom);
      bus.ex_rd          = 5'($urandom_range(0, 3));
      bus.ex_mem_read    = ($urandom_range(0, 9) < 4);
      bus.ex_redirect    = ($urandom_range(0, 99) < 8);
      bus.ex_redirect_pc = {$urandom, $urandom};
      bus.mtvec          = {$urandom, $urandom};
      #1;
      run_cycle();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
